// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: frame sequencer in front of the DCSK TX core.
// Sends PREAMBLE_LEN preamble words, then a payload pulled by valid/ready,
// waits for the core to drain and holds a guard gap before signalling done.
module tx_frame_ctrl #(
    parameter int               MSG_W         = 8,
    parameter int               CTR_W         = 10,
    parameter int               LEN_W         = 8,
    parameter int               PREAMBLE_LEN  = 2,
    parameter logic [MSG_W-1:0] PREAMBLE_WORD = 8'hAA,
    parameter int               GUARD_CYCLES  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_frame_len,
    input  logic [CTR_W-1:0] i_cfg_wrap,
    input  logic             i_abort,
    input  logic [MSG_W-1:0] i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    input  logic             i_core_load,
    input  logic             i_core_sending,
    output logic             o_core_send,
    output logic [MSG_W-1:0] o_core_msg,
    output logic [CTR_W-1:0] o_core_wrap,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_DRAIN,
        S_GUARD
    } state_t;

    localparam int               GW    = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0]    GLAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [LEN_W-1:0] PLAST = LEN_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic             r_staged_valid;
    logic [MSG_W-1:0] r_core_msg;
    logic [CTR_W-1:0] r_core_wrap;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_fetch_left;
    logic [LEN_W-1:0] r_pre_cnt;
    logic [LEN_W-1:0] r_sent_cnt;
    logic [GW-1:0]    r_guard_cnt;
    logic             r_underrun;
    logic             r_sending_d;

    logic w_active;
    logic w_consume;
    logic w_abort;
    logic w_underrun;
    logic w_last_pre;
    logic w_fetch;
    logic w_accept;
    logic w_guard_done;

    assign w_active     = (r_state == S_PRE) || (r_state == S_PAY);
    assign o_core_send  = r_staged_valid && w_active;
    assign w_consume    = i_core_load && o_core_send;
    assign w_abort      = i_abort && w_active;
    assign w_underrun   = (r_state == S_PAY) && r_sending_d && !i_core_sending;
    assign w_last_pre   = (r_state == S_PRE) && (r_pre_cnt == PLAST);
    // Abort and underrun both drop the staged word, so nothing may be fetched in that cycle.
    assign o_data_ready = (r_fetch_left != '0) && (!r_staged_valid || w_consume)
                          && ((r_state == S_PAY) || w_last_pre) && !w_abort && !w_underrun;
    assign w_fetch      = i_data_valid && o_data_ready;
    assign w_accept     = (r_state == S_IDLE) && i_start && (i_frame_len != '0);
    assign w_guard_done = (r_state == S_GUARD) && ((GUARD_CYCLES == 0) || (r_guard_cnt == GLAST));

    assign o_core_msg  = r_core_msg;
    assign o_core_wrap = r_core_wrap;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = w_guard_done;
    assign o_underrun  = r_underrun;

    // Next-state decode; abort takes priority over underrun and over any consume.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (PREAMBLE_LEN > 0) ? S_PRE : S_PAY;
            S_PRE: begin
                if (w_abort)                              w_next = S_DRAIN;
                else if (w_consume && r_pre_cnt == PLAST) w_next = S_PAY;
            end
            S_PAY: begin
                if (w_abort)                                         w_next = S_DRAIN;
                else if (w_underrun)                                 w_next = S_GUARD;
                else if (w_consume && r_sent_cnt == r_len - 1'b1)    w_next = S_DRAIN;
            end
            S_DRAIN: if (!i_core_sending) w_next = S_GUARD;
            S_GUARD: if (w_guard_done)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, staging register, counters and sticky status.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_staged_valid <= 1'b0;
            r_core_msg     <= '0;
            r_core_wrap    <= '0;
            r_len          <= '0;
            r_fetch_left   <= '0;
            r_pre_cnt      <= '0;
            r_sent_cnt     <= '0;
            r_guard_cnt    <= '0;
            r_underrun     <= 1'b0;
            r_sending_d    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sending_d <= i_core_sending;

            if (r_state == S_GUARD && !w_guard_done) r_guard_cnt <= r_guard_cnt + 1'b1;
            else                                      r_guard_cnt <= '0;

            if (w_accept) begin
                r_len        <= i_frame_len;
                r_core_wrap  <= i_cfg_wrap;
                r_underrun   <= 1'b0;
                r_fetch_left <= i_frame_len;
                r_pre_cnt    <= '0;
                r_sent_cnt   <= '0;
                if (PREAMBLE_LEN > 0) begin
                    r_core_msg     <= PREAMBLE_WORD;
                    r_staged_valid <= 1'b1;
                end
            end else if (w_abort || w_underrun) begin
                r_staged_valid <= 1'b0;
                r_underrun     <= 1'b1;
            end else begin
                // A refill in the consume cycle keeps the stage full with no bubble.
                if (w_fetch) begin
                    r_core_msg     <= i_data;
                    r_staged_valid <= 1'b1;
                    r_fetch_left   <= r_fetch_left - 1'b1;
                end else if (w_consume) begin
                    if (r_state == S_PRE && r_pre_cnt != PLAST) begin
                        r_core_msg <= PREAMBLE_WORD;
                    end else begin
                        r_staged_valid <= 1'b0;
                    end
                end
                if (w_consume && r_state == S_PRE) r_pre_cnt  <= r_pre_cnt + 1'b1;
                if (w_consume && r_state == S_PAY) r_sent_cnt <= r_sent_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb_tx_frame_ctrl: scoreboard bench with a behavioural TX core and upstream source.
module tb_tx_frame_ctrl;

    localparam int MSG_W    = 8;
    localparam int CTR_W    = 10;
    localparam int LEN_W    = 8;
    localparam int WORD_CYC = 6;

    logic             clk = 1'b0;
    logic             i_rst, i_start, i_abort, i_data_valid;
    logic [LEN_W-1:0] i_frame_len;
    logic [CTR_W-1:0] i_cfg_wrap;
    logic [MSG_W-1:0] i_data;
    logic             o_data_ready, i_core_load, i_core_sending, o_core_send;
    logic [MSG_W-1:0] o_core_msg;
    logic [CTR_W-1:0] o_core_wrap;
    logic             o_busy, o_done, o_underrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [MSG_W-1:0] exp_q[$];
    logic [MSG_W-1:0] got_q[$];

    always #5 clk = ~clk;

    tx_frame_ctrl #(
        .MSG_W(MSG_W), .CTR_W(CTR_W), .LEN_W(LEN_W),
        .PREAMBLE_LEN(2), .PREAMBLE_WORD(8'hAA), .GUARD_CYCLES(16)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_frame_len(i_frame_len),
        .i_cfg_wrap(i_cfg_wrap), .i_abort(i_abort), .i_data(i_data),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .i_core_load(i_core_load), .i_core_sending(i_core_sending),
        .o_core_send(o_core_send), .o_core_msg(o_core_msg), .o_core_wrap(o_core_wrap),
        .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun)
    );

    // Core model: a word lasts WORD_CYC clocks; a new word loads when idle or at the last clock.
    logic m_sending = 1'b0;
    int   m_cnt     = 0;
    assign i_core_load    = o_core_send && (!m_sending || m_cnt == 0);
    assign i_core_sending = m_sending;
    always @(posedge clk) begin
        if (i_rst) begin
            m_sending <= 1'b0;
            m_cnt     <= 0;
        end else if (i_core_load) begin
            m_sending <= 1'b1;
            m_cnt     <= WORD_CYC - 1;
            got_q.push_back(o_core_msg);
        end else if (m_sending) begin
            if (m_cnt == 0) m_sending <= 1'b0;
            else            m_cnt     <= m_cnt - 1;
        end
    end

    // Upstream source: word value is D0 plus the running handshake count.
    int up_acc = 0;
    assign i_data = 8'hD0 + 8'(up_acc);
    always @(posedge clk) if (i_data_valid && o_data_ready) up_acc <= up_acc + 1;

    // Monitor: cycle stamps of the last sending fall and of each done pulse.
    int   ncyc = 0, t_fall = -1, t_done = -1, done_cnt = 0;
    logic prev_send = 1'b0;
    always @(negedge clk) begin
        if (prev_send && !i_core_sending) t_fall <= ncyc;
        prev_send <= i_core_sending;
        if (o_done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= ncyc;
        end
        ncyc <= ncyc + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len, input logic [CTR_W-1:0] wrap);
        i_frame_len = len;
        i_cfg_wrap  = wrap;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic push_exp(input int n_pay, input int base);
        exp_q.delete();
        got_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        for (int k = 0; k < n_pay; k++) exp_q.push_back(8'hD0 + 8'(base + k));
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_data_valid = 1'b0;
        i_frame_len = '0; i_cfg_wrap = '0;
        repeat (3) tick();
        n_checks++;
        if ({o_data_ready, o_core_send, o_busy, o_done, o_underrun} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {o_data_ready, o_core_send, o_busy, o_done, o_underrun});
        end
        n_checks++;
        if (o_core_msg !== 8'h00) begin
            n_errors++; $display("FAIL reset_msg got=%h exp=00", o_core_msg);
        end
        n_checks++;
        if (o_core_wrap !== 10'h000) begin
            n_errors++; $display("FAIL reset_wrap got=%h exp=000", o_core_wrap);
        end
        i_rst = 1'b0;
        tick();
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle busy got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_basic();
        int  base, d0;
        bit  ok;
        base = up_acc;
        d0   = done_cnt;
        push_exp(3, base);
        i_data_valid = 1'b1;
        start_frame(8'd3, 10'h155);
        n_checks++;
        if ({o_busy, o_core_send} !== 2'b11 || o_core_wrap !== 10'h155) begin
            n_errors++;
            $display("FAIL basic_accept busy/send=%b wrap=%h exp=11 155", {o_busy, o_core_send}, o_core_wrap);
        end
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (got_q.size() == 5) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || o_core_send !== 1'b0 || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_send_fall reached=%0d send=%b busy=%b exp=1 0 1", ok, o_core_send, o_busy);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL basic_done timeout got=0 exp=1"); end
        n_checks++;
        if (t_done - t_fall !== 16) begin
            n_errors++; $display("FAIL basic_guard got=%0d exp=16", t_done - t_fall);
        end
        n_checks++;
        if (o_underrun !== 1'b0 || done_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL basic_status underrun=%b dones=%0d exp=0 1", o_underrun, done_cnt - d0);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL basic_nloads got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        tick();
        n_checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            n_errors++; $display("FAIL basic_idle busy/done=%b exp=00", {o_busy, o_done});
        end
        i_data_valid = 1'b0;
    endtask

    task automatic test_valid_gap();
        int base;
        bit ok;
        base = up_acc;
        push_exp(3, base);
        i_data_valid = 1'b1;
        start_frame(8'd3, 10'h0C3);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (up_acc - base == 1 && o_data_ready) begin ok = 1'b1; break; end
        end
        i_data_valid = 1'b0;
        tick();
        i_data_valid = 1'b1;
        n_checks++;
        if (!ok || o_data_ready !== 1'b1 || o_core_send !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_wait reached=%0d ready=%b send=%b exp=1 1 0", ok, o_data_ready, o_core_send);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || o_underrun !== 1'b0 || up_acc - base !== 3) begin
            n_errors++;
            $display("FAIL gap_status done=%0d underrun=%b taken=%0d exp=1 0 3", ok, o_underrun, up_acc - base);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL gap_nloads got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL gap_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        i_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        int base;
        bit ok;
        base = up_acc;
        push_exp(1, base);
        i_data_valid = 1'b1;
        start_frame(8'd3, 10'h2A5);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (up_acc - base == 1) break;
        end
        i_data_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (o_underrun) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || {o_busy, o_core_send, o_data_ready} !== 3'b100) begin
            n_errors++;
            $display("FAIL underrun_set seen=%0d busy/send/ready=%b exp=1 100", ok,
                     {o_busy, o_core_send, o_data_ready});
        end
        i_data_valid = 1'b1;
        wait_done(100, ok);
        n_checks++;
        if (!ok || up_acc - base !== 1) begin
            n_errors++; $display("FAIL underrun_done done=%0d taken=%0d exp=1 1", ok, up_acc - base);
        end
        tick();
        n_checks++;
        if (o_underrun !== 1'b1 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL underrun_sticky underrun=%b busy=%b exp=1 0", o_underrun, o_busy);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL underrun_nloads got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL underrun_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        i_data_valid = 1'b0;
    endtask

    task automatic test_abort();
        int base, d0;
        bit ok;
        base = up_acc;
        d0   = done_cnt;
        push_exp(2, base);
        i_data_valid = 1'b1;
        start_frame(8'd3, 10'h0F0);
        n_checks++;
        if (o_underrun !== 1'b0) begin
            n_errors++; $display("FAIL abort_clear_underrun got=%b exp=0", o_underrun);
        end
        for (int k = 0; k < 200; k++) begin
            tick();
            if (got_q.size() == 4) break;
        end
        tick();
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_checks++;
        if ({o_core_send, o_data_ready, o_underrun, o_busy} !== 4'b0011) begin
            n_errors++;
            $display("FAIL abort_state send/ready/underrun/busy=%b exp=0011",
                     {o_core_send, o_data_ready, o_underrun, o_busy});
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || t_done - t_fall !== 16 || done_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL abort_done done=%0d guard=%0d dones=%0d exp=1 16 1", ok, t_done - t_fall, done_cnt - d0);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL abort_nloads got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errors++; $display("FAIL abort_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
        i_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_ignored_start();
        int base, d0;
        bit ok;
        d0 = done_cnt;
        start_frame(8'd0, 10'h3FF);
        n_checks++;
        if (o_busy !== 1'b0) begin n_errors++; $display("FAIL len0_busy got=%b exp=0", o_busy); end
        repeat (20) tick();
        n_checks++;
        if (done_cnt !== d0 || o_core_wrap !== 10'h0F0) begin
            n_errors++;
            $display("FAIL len0_quiet dones=%0d wrap=%h exp=0 0f0", done_cnt - d0, o_core_wrap);
        end
        base = up_acc;
        push_exp(3, base);
        i_data_valid = 1'b1;
        start_frame(8'd3, 10'h111);
        tick();
        start_frame(8'd5, 10'h222);
        n_checks++;
        if (o_core_wrap !== 10'h111 || o_busy !== 1'b1) begin
            n_errors++; $display("FAIL busy_start wrap=%h busy=%b exp=111 1", o_core_wrap, o_busy);
        end
        wait_done(200, ok);
        n_checks++;
        if (!ok || done_cnt - d0 !== 1 || up_acc - base !== 3) begin
            n_errors++;
            $display("FAIL busy_done done=%0d dones=%0d taken=%0d exp=1 1 3", ok, done_cnt - d0, up_acc - base);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_errors++; $display("FAIL busy_nloads got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        i_data_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int d0;
        i_data_valid = 1'b1;
        got_q.delete();
        start_frame(8'd3, 10'h0AB);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (got_q.size() == 3) break;
        end
        d0 = done_cnt;
        i_rst = 1'b1;
        tick();
        n_checks++;
        if ({o_data_ready, o_core_send, o_busy, o_done, o_underrun} !== 5'b0
            || o_core_msg !== 8'h00 || o_core_wrap !== 10'h000) begin
            n_errors++;
            $display("FAIL midrst_outputs flags=%b msg=%h wrap=%h exp=00000 00 000",
                     {o_data_ready, o_core_send, o_busy, o_done, o_underrun}, o_core_msg, o_core_wrap);
        end
        i_rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (done_cnt !== d0 || o_busy !== 1'b0) begin
            n_errors++; $display("FAIL midrst_nodone dones=%0d busy=%b exp=0 0", done_cnt - d0, o_busy);
        end
        i_data_valid = 1'b0;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_valid_gap();
        test_underrun();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
